i2c_slave_regbank: RTL and testbench

//  I2C target (slave) that answers one fixed 7-bit address and exposes a bank of NUM_REGS 8-bit registers.
//  Bus side: standard write (pointer byte, then data bytes) and read, with auto-increment and repeated START.

---
 rtl/i2c_slave_regbank.sv | 193 +++++++++++++++++++
 tb/tb_i2c_slave_regbank.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regbank.sv
// I2C target answering one 7-bit address and exposing NUM_REGS 8-bit registers,
// with auto-increment, repeated START and a local read/write port into the same bank.
module i2c_slave_regbank #(
  parameter logic [6:0] SLAVE_ADDR = 7'h42,
  parameter int         NUM_REGS   = 16,
  parameter int         ADDR_W     = 4,
  parameter int         FILTER_LEN = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              scl,
  inout  wire               sda,
  input  logic [ADDR_W-1:0] reg_addr,
  input  logic              reg_we,
  input  logic [7:0]        reg_wdata,
  output logic [7:0]        reg_rdata,
  output logic              busy,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_index
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, WR_DATA, WR_ACK, RD_DATA, RD_ACK, RD_LOAD, IGNORE
  } state_t;

  function automatic logic settle(input logic [FILTER_LEN-1:0] win, input logic cur);
    if (&win)       return 1'b1;
    else if (~|win) return 1'b0;
    else            return cur;
  endfunction

  state_t state, state_nxt;

  logic scl_p0, scl_p1, sda_p0, sda_p1;
  logic [FILTER_LEN-2:0] scl_hist, sda_hist;
  logic [FILTER_LEN-1:0] scl_win, sda_win;
  logic scl_f, sda_f, scl_d, sda_d;
  logic scl_rise, scl_fall, start, stop;

  logic [7:0]        regs [NUM_REGS];
  logic [7:0]        shifter;
  logic [7:0]        rx_byte;
  logic [2:0]        bit_cnt;
  logic [ADDR_W-1:0] ptr;
  logic              rw, ack_low, tx_en, drive_low;

  assign scl_win = {scl_hist, scl_p1};
  assign sda_win = {sda_hist, sda_p1};

  // Stage p0/p1: synchronisers, then the stability filter; idle bus level is high
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scl_p0   <= 1'b1;
      scl_p1   <= 1'b1;
      sda_p0   <= 1'b1;
      sda_p1   <= 1'b1;
      scl_hist <= '1;
      sda_hist <= '1;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_p0   <= scl;
      scl_p1   <= scl_p0;
      sda_p0   <= sda;
      sda_p1   <= sda_p0;
      scl_hist <= scl_win[FILTER_LEN-2:0];
      sda_hist <= sda_win[FILTER_LEN-2:0];
      scl_f    <= settle(scl_win, scl_f);
      sda_f    <= settle(sda_win, sda_f);
      scl_d    <= scl_f;
      sda_d    <= sda_f;
    end
  end

  assign scl_rise = scl_f & ~scl_d;
  assign scl_fall = ~scl_f & scl_d;
  assign start    = scl_f & scl_d & sda_d & ~sda_f;
  assign stop     = scl_f & scl_d & ~sda_d & sda_f;
  assign rx_byte  = {shifter[6:0], sda_f};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // ACK states hold the line for one full bit: first falling edge asserts, second ends it
  always_comb begin
    state_nxt = state;
    if (start) state_nxt = ADDR;
    else if (stop) state_nxt = IDLE;
    else begin
      case (state)
        ADDR:     if (scl_rise && bit_cnt == 3'd0)
                    state_nxt = (rx_byte[7:1] == SLAVE_ADDR) ? ADDR_ACK : IGNORE;
        ADDR_ACK: if (scl_fall && ack_low) state_nxt = rw ? RD_DATA : PTR;
        PTR:      if (scl_rise && bit_cnt == 3'd0) state_nxt = WR_ACK;
        WR_DATA:  if (scl_rise && bit_cnt == 3'd0) state_nxt = WR_ACK;
        WR_ACK:   if (scl_fall && ack_low) state_nxt = WR_DATA;
        RD_DATA:  if (scl_fall && bit_cnt == 3'd0) state_nxt = RD_ACK;
        RD_ACK:   if (scl_rise) state_nxt = sda_f ? IGNORE : RD_LOAD;
        RD_LOAD:  if (scl_fall) state_nxt = RD_DATA;
        default:  state_nxt = state;
      endcase
    end
  end

  // Stage p2: bus datapath and register bank; bus commit is written last so it wins a collision
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      reg_rdata <= '0;
      shifter   <= '0;
      bit_cnt   <= 3'd7;
      ptr       <= '0;
      rw        <= 1'b0;
      ack_low   <= 1'b0;
      tx_en     <= 1'b0;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      wr_index  <= '0;
    end else begin
      wr_strobe <= 1'b0;
      if (reg_we) regs[reg_addr] <= reg_wdata;
      reg_rdata <= regs[reg_addr];
      if (start) begin
        bit_cnt <= 3'd7;
        ack_low <= 1'b0;
        tx_en   <= 1'b0;
      end else if (stop) begin
        ack_low <= 1'b0;
        tx_en   <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          ADDR: if (scl_rise) begin
            shifter <= rx_byte;
            bit_cnt <= bit_cnt - 3'd1;
            if (bit_cnt == 3'd0 && rx_byte[7:1] == SLAVE_ADDR) begin
              rw   <= rx_byte[0];
              busy <= 1'b1;
            end
          end
          PTR: if (scl_rise) begin
            shifter <= rx_byte;
            bit_cnt <= bit_cnt - 3'd1;
            if (bit_cnt == 3'd0) ptr <= rx_byte[ADDR_W-1:0];
          end
          WR_DATA: if (scl_rise) begin
            shifter <= rx_byte;
            bit_cnt <= bit_cnt - 3'd1;
            if (bit_cnt == 3'd0) begin
              regs[ptr] <= rx_byte;
              wr_strobe <= 1'b1;
              wr_index  <= ptr;
              ptr       <= ptr + ADDR_W'(1);
            end
          end
          ADDR_ACK, WR_ACK: if (scl_fall) begin
            if (!ack_low) ack_low <= 1'b1;
            else begin
              ack_low <= 1'b0;
              if (state == ADDR_ACK && rw) begin
                shifter <= regs[ptr];
                tx_en   <= 1'b1;
              end
            end
          end
          RD_DATA: if (scl_fall) begin
            bit_cnt <= bit_cnt - 3'd1;
            if (bit_cnt == 3'd0) begin
              tx_en <= 1'b0;
              ptr   <= ptr + ADDR_W'(1);
            end else begin
              shifter <= {shifter[6:0], 1'b0};
            end
          end
          RD_LOAD: if (scl_fall) begin
            shifter <= regs[ptr];
            tx_en   <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Open-drain: a 1 is never driven, and reset releases the line without waiting for a clock
  assign drive_low = ack_low | (tx_en & ~shifter[7]);
  assign sda       = (drive_low && !reset) ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_slave_regbank.sv
// Bench for i2c_slave_regbank: bit-banged I2C master plus a register/pointer model of the target.
module tb_i2c_slave_regbank;
  localparam int Q = 10;

  logic       clock = 1'b0;
  logic       reset;
  logic       scl;
  logic       m_sda;
  wire        sda;
  logic [3:0] reg_addr;
  logic       reg_we;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic       busy;
  logic       wr_strobe;
  logic [3:0] wr_index;

  int errors = 0;
  int checks = 0;
  logic [7:0] model_regs [16];
  int model_ptr;
  int strobe_q[$];
  logic ack_b;
  logic [7:0] rnd_d;
  int rnd_n;

  pullup (sda);
  assign sda = m_sda ? 1'bz : 1'b0;

  i2c_slave_regbank dut (
    .clock(clock), .reset(reset), .scl(scl), .sda(sda),
    .reg_addr(reg_addr), .reg_we(reg_we), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .busy(busy), .wr_strobe(wr_strobe), .wr_index(wr_index)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (wr_strobe) strobe_q.push_back(int'(wr_index));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wq(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic start_c();
    m_sda = 1'b1; wq(Q); scl = 1'b1; wq(Q); m_sda = 1'b0; wq(Q); scl = 1'b0; wq(Q);
  endtask

  task automatic stop_c();
    m_sda = 1'b0; wq(Q); scl = 1'b1; wq(Q); m_sda = 1'b1; wq(Q);
  endtask

  task automatic wbit(input logic b);
    m_sda = b; wq(Q); scl = 1'b1; wq(2*Q); scl = 1'b0; wq(Q);
  endtask

  task automatic rbit(output logic b);
    m_sda = 1'b1; wq(Q); scl = 1'b1; wq(Q); b = sda; wq(Q); scl = 1'b0; wq(Q);
  endtask

  task automatic wbyte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) wbit(b[i]);
    rbit(ack);
  endtask

  task automatic rbyte(input logic mack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      rbit(b);
      d[i] = b;
    end
    wbit(mack);
  endtask

  task automatic send_addr(input logic [7:0] a, input logic exp_ack, input string tag);
    logic ack;
    wbyte(a, ack);
    check({tag, "_addr_ack"}, ack, exp_ack);
  endtask

  task automatic send_ptr(input logic [7:0] p, input string tag);
    logic ack;
    wbyte(p, ack);
    check({tag, "_ptr_ack"}, ack, 1'b0);
    check({tag, "_ptr_nostrobe"}, strobe_q.size(), 0);
    model_ptr = p % 16;
  endtask

  task automatic send_data(input logic [7:0] d, input string tag);
    logic ack;
    wbyte(d, ack);
    check({tag, "_ack"}, ack, 1'b0);
    check({tag, "_nstrobe"}, strobe_q.size(), 1);
    if (strobe_q.size() > 0) check({tag, "_idx"}, strobe_q.pop_front(), model_ptr);
    strobe_q.delete();
    model_regs[model_ptr] = d;
    model_ptr = (model_ptr + 1) % 16;
  endtask

  task automatic recv_data(input logic mack, input string tag);
    logic [7:0] d;
    rbyte(mack, d);
    check(tag, d, model_regs[model_ptr]);
    model_ptr = (model_ptr + 1) % 16;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 16; i++) begin
      reg_addr = 4'(i);
      wq(2);
      check($sformatf("%s[%0d]", tag, i), reg_rdata, model_regs[i]);
    end
  endtask

  initial begin
    reset = 1'b1; scl = 1'b1; m_sda = 1'b1;
    reg_addr = '0; reg_we = 1'b0; reg_wdata = '0;
    for (int i = 0; i < 16; i++) model_regs[i] = 8'h00;
    model_ptr = 0;
    wq(3);
    check("rst_busy", busy, 1'b0);
    check("rst_strobe", wr_strobe, 1'b0);
    check("rst_rdata", reg_rdata, 8'h00);
    check("rst_sda", sda, 1'b1);
    reset = 1'b0;
    wq(Q);

    // Write: pointer 3, data A5 5A
    start_c();
    send_addr(8'h84, 1'b0, "wr");
    check("wr_busy", busy, 1'b1);
    send_ptr(8'h03, "wr");
    send_data(8'hA5, "wr0");
    send_data(8'h5A, "wr1");
    stop_c(); wq(Q);
    check("wr_busy_end", busy, 1'b0);
    check_regs("wr_regs");

    // Read with repeated START
    start_c();
    send_addr(8'h84, 1'b0, "rd");
    send_ptr(8'h03, "rd");
    start_c();
    send_addr(8'h85, 1'b0, "rd_sr");
    recv_data(1'b0, "rd_byte0");
    recv_data(1'b1, "rd_byte1");
    check("rd_sda_after_nack", sda, 1'b1);
    stop_c(); wq(Q);
    check("rd_busy_end", busy, 1'b0);

    // Write with no pointer byte keeps the pointer; a read continues from it
    start_c(); send_addr(8'h84, 1'b0, "noptr"); stop_c();
    start_c(); send_addr(8'h85, 1'b0, "noptr_rd");
    recv_data(1'b1, "noptr_byte");
    stop_c(); wq(Q);

    // Address mismatch
    start_c();
    send_addr(8'h86, 1'b1, "mis");
    send_addr(8'h00, 1'b1, "mis_data");
    check("mis_busy", busy, 1'b0);
    stop_c(); wq(Q);
    check("mis_nostrobe", strobe_q.size(), 0);
    check_regs("mis_regs");

    // Pointer wrap
    start_c();
    send_addr(8'h84, 1'b0, "wrap");
    send_ptr(8'h1F, "wrap");
    send_data(8'h11, "wrap0");
    send_data(8'h22, "wrap1");
    stop_c(); wq(Q);
    check_regs("wrap_regs");

    // One-cycle sda glitch on an idle bus must not look like START
    m_sda = 1'b0; wq(1); m_sda = 1'b1; wq(Q);
    check("glitch_busy", busy, 1'b0);
    check("glitch_sda", sda, 1'b1);
    scl = 1'b0; wq(Q);
    wbyte(8'h84, ack_b);
    check("glitch_noack", ack_b, 1'b1);
    stop_c(); wq(Q);
    check("glitch_nostrobe", strobe_q.size(), 0);

    // Randomised traffic from both sides
    for (int t = 0; t < 5; t++) begin
      start_c();
      send_addr(8'h84, 1'b0, "rnd_w");
      send_ptr(8'($urandom_range(0, 255)), "rnd_w");
      rnd_n = $urandom_range(1, 3);
      for (int k = 0; k < rnd_n; k++) send_data(8'($urandom_range(0, 255)), "rnd_wd");
      stop_c(); wq(Q);

      rnd_d = 8'($urandom_range(0, 255));
      reg_addr = 4'($urandom_range(0, 15));
      reg_wdata = rnd_d;
      reg_we = 1'b1; wq(1); reg_we = 1'b0;
      model_regs[reg_addr] = rnd_d;

      start_c();
      send_addr(8'h84, 1'b0, "rnd_r");
      send_ptr(8'($urandom_range(0, 255)), "rnd_r");
      start_c();
      send_addr(8'h85, 1'b0, "rnd_r_sr");
      rnd_n = $urandom_range(1, 3);
      for (int k = 0; k < rnd_n; k++) recv_data(k == rnd_n - 1, "rnd_rd");
      stop_c(); wq(Q);
    end
    check_regs("rnd_regs");

    // Reset while the target drives a 0 data bit
    start_c();
    send_addr(8'h84, 1'b0, "rst_prep");
    send_ptr(8'h07, "rst_prep");
    send_data(8'h00, "rst_prep");
    stop_c();
    start_c();
    send_addr(8'h84, 1'b0, "rst_rd");
    send_ptr(8'h07, "rst_rd");
    start_c();
    send_addr(8'h85, 1'b0, "rst_rd_sr");
    check("rst_rd_drive0", sda, 1'b0);
    reset = 1'b1;
    #1;
    check("rst_sda_release", sda, 1'b1);
    wq(2);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) model_regs[i] = 8'h00;
    model_ptr = 0;
    strobe_q.delete();
    check("rst_mid_busy", busy, 1'b0);
    stop_c(); wq(Q);
    check_regs("rst_regs");
    start_c();
    send_addr(8'h84, 1'b0, "post");
    send_ptr(8'h02, "post");
    send_data(8'h3C, "post0");
    send_data(8'hC3, "post1");
    stop_c(); wq(Q);
    check_regs("post_regs");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
